// File: rtl/struct_pckg.sv
// Shared pipeline-bus layout constants and width helpers for the elastic stage FIFO.
// Flattened bus, MSB to LSB: pc, instr, rd_addr, result, mem_be, is_valid.
package struct_pckg;

  localparam int PIPE_XLEN_DEFAULT = 64;
  localparam int PIPE_INSTR_W      = 32;
  localparam int PIPE_RF_ADDR_W    = 5;
  localparam int PIPE_MEM_BE_W     = PIPE_XLEN_DEFAULT / 8;
  localparam int PIPE_VALID_BIT    = 0;

  function automatic int pipe_mem_be_w(input int xlen);
    return xlen / 8;
  endfunction

  function automatic int PIPE_BUS_W(input int xlen);
    return 2 * xlen + PIPE_INSTR_W + PIPE_RF_ADDR_W + pipe_mem_be_w(xlen) + 1;
  endfunction

endpackage

// File: rtl/pipe_stage_fifo_if.sv
// Valid/ready handshake bundle for both sides of the elastic stage.
interface pipe_stage_fifo_if #(
  parameter int DATA_W = 8
) ();

  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;

  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o
  );

  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o
  );

endinterface

// File: rtl/pipe_fifo_mem.sv
// DEPTH x DATA_W storage: synchronous write, asynchronous read, cleared by reset.
module pipe_fifo_mem #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_wrEn,
  input  logic [$clog2(DEPTH)-1:0] i_wrAddr,
  input  logic [DATA_W-1:0]        i_wrData,
  input  logic [$clog2(DEPTH)-1:0] i_rdAddr,
  output logic [DATA_W-1:0]        o_rdData
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
  end

  assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/pipe_stage_fifo.sv
// Elastic pipeline stage: DEPTH-entry in-order queue with flush, bubble drop and bypass.
module pipe_stage_fifo
  import struct_pckg::*;
#(
  parameter int XLEN         = 64,
  parameter int DEPTH        = 2,
  parameter int DATA_W       = PIPE_BUS_W(XLEN),
  parameter int BYPASS       = 0,
  parameter int DROP_BUBBLES = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  pipe_stage_fifo_if.slave           bus,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;

  logic              w_empty;
  logic              w_full;
  logic              w_inReady;
  logic              w_isBubble;
  logic              w_bypassActive;
  logic              w_outValid;
  logic              w_inFire;
  logic              w_pop;
  logic              w_store;
  logic              w_popStored;
  logic [DATA_W-1:0] w_rdData;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_inReady = !w_full && !flush_i;

  // Bubbles still handshake upstream but never reach storage or the bypass path.
  assign w_isBubble     = (DROP_BUBBLES != 0) && !bus.in_data_i[PIPE_VALID_BIT];
  assign w_bypassActive = (BYPASS != 0) && w_empty;

  assign w_outValid = w_bypassActive ? (bus.in_valid_i && !flush_i && !w_isBubble)
                                     : !w_empty;

  assign w_inFire    = bus.in_valid_i && w_inReady;
  assign w_pop       = w_outValid && bus.out_ready_i;
  assign w_store     = w_inFire && !w_isBubble && !(w_bypassActive && w_pop);
  assign w_popStored = w_pop && !w_bypassActive;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_store)     r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_popStored) r_rdPtr <= r_rdPtr + PTR_W'(1);
      if (w_store && !w_popStored)      r_count <= r_count + CNT_W'(1);
      else if (!w_store && w_popStored) r_count <= r_count - CNT_W'(1);
    end
  end

  pipe_fifo_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_wrEn   (w_store && !flush_i),
    .i_wrAddr (r_wrPtr),
    .i_wrData (bus.in_data_i),
    .i_rdAddr (r_rdPtr),
    .o_rdData (w_rdData)
  );

  assign bus.in_ready_o  = w_inReady;
  assign bus.out_valid_o = w_outValid;
  assign bus.out_data_o  = w_bypassActive ? bus.in_data_i : w_rdData;

  assign count_o = r_count;
  assign full_o  = w_full;
  assign empty_o = w_empty;

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Directed bench: instance A (DEPTH=2, plain queue) and instance B (DEPTH=4, bypass + bubble drop).
module tb_pipe_stage_fifo;
  import struct_pckg::*;

  localparam int DW = PIPE_BUS_W(64);

  logic clk;
  logic rstN;
  logic flushA;
  logic flushB;
  logic [1:0] countA;
  logic [2:0] countB;
  logic fullA, emptyA, fullB, emptyB;
  int nChecks;
  int nFails;

  pipe_stage_fifo_if #(.DATA_W(DW)) busA ();
  pipe_stage_fifo_if #(.DATA_W(DW)) busB ();

  pipe_stage_fifo #(.XLEN(64), .DEPTH(2), .DATA_W(DW), .BYPASS(0), .DROP_BUBBLES(0)) dutA (
    .clk(clk), .rst_n(rstN), .flush_i(flushA), .bus(busA.slave),
    .count_o(countA), .full_o(fullA), .empty_o(emptyA)
  );

  pipe_stage_fifo #(.XLEN(64), .DEPTH(4), .DATA_W(DW), .BYPASS(1), .DROP_BUBBLES(1)) dutB (
    .clk(clk), .rst_n(rstN), .flush_i(flushB), .bus(busB.slave),
    .count_o(countB), .full_o(fullB), .empty_o(emptyB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    #1;
    nChecks++; if (busA.out_valid_o !== 1'b0) begin nFails++; $display("[TB] FAIL reset_valid: got %b want 0", busA.out_valid_o); end
    nChecks++; if (countA !== 2'd0) begin nFails++; $display("[TB] FAIL reset_count: got %0d want 0", countA); end
    nChecks++; if (emptyA !== 1'b1 || fullA !== 1'b0) begin nFails++; $display("[TB] FAIL reset_flags: empty %b full %b want 1 0", emptyA, fullA); end
    nChecks++; if (busA.in_ready_o !== 1'b1) begin nFails++; $display("[TB] FAIL reset_ready: got %b want 1", busA.in_ready_o); end
    nChecks++; if (busA.out_data_o !== DW'(0)) begin nFails++; $display("[TB] FAIL reset_data: got %h want 0", busA.out_data_o); end
    #11;
    rstN = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    busA.in_valid_i = 1'b1; busA.in_data_i = DW'('hA); busA.out_ready_i = 1'b0;
    tick();
    nChecks++; if (busA.out_valid_o !== 1'b1 || busA.out_data_o !== DW'('hA)) begin nFails++; $display("[TB] FAIL b2b_first: valid %b data %h want 1 a", busA.out_valid_o, busA.out_data_o); end
    busA.in_data_i = DW'('hB);
    tick();
    busA.in_valid_i = 1'b0;
    #1;
    nChecks++; if (countA !== 2'd2 || fullA !== 1'b1) begin nFails++; $display("[TB] FAIL b2b_full: count %0d full %b want 2 1", countA, fullA); end
    nChecks++; if (busA.in_ready_o !== 1'b0) begin nFails++; $display("[TB] FAIL b2b_ready: got %b want 0", busA.in_ready_o); end
    busA.out_ready_i = 1'b1;
    #1;
    nChecks++; if (busA.out_data_o !== DW'('hA)) begin nFails++; $display("[TB] FAIL b2b_pop0: got %h want a", busA.out_data_o); end
    tick();
    nChecks++; if (busA.out_data_o !== DW'('hB) || countA !== 2'd1) begin nFails++; $display("[TB] FAIL b2b_pop1: data %h count %0d want b 1", busA.out_data_o, countA); end
    tick();
    nChecks++; if (emptyA !== 1'b1 || busA.out_valid_o !== 1'b0) begin nFails++; $display("[TB] FAIL b2b_drain: empty %b valid %b want 1 0", emptyA, busA.out_valid_o); end
    busA.out_ready_i = 1'b0;
  endtask

  task automatic test_push_pop();
    busA.in_valid_i = 1'b1; busA.in_data_i = DW'('hE);
    tick();
    busA.in_data_i = DW'('hC); busA.out_ready_i = 1'b1;
    #1;
    nChecks++; if (busA.out_data_o !== DW'('hE)) begin nFails++; $display("[TB] FAIL pp_head: got %h want e", busA.out_data_o); end
    tick();
    busA.in_valid_i = 1'b0; busA.out_ready_i = 1'b0;
    #1;
    nChecks++; if (countA !== 2'd1 || busA.out_data_o !== DW'('hC)) begin nFails++; $display("[TB] FAIL pp_after: count %0d data %h want 1 c", countA, busA.out_data_o); end
  endtask

  task automatic test_flush();
    busA.in_valid_i = 1'b1; busA.in_data_i = DW'('hF);
    tick();
    nChecks++; if (countA !== 2'd2) begin nFails++; $display("[TB] FAIL fl_pre: count %0d want 2", countA); end
    flushA = 1'b1; busA.in_data_i = DW'('hD); busA.out_ready_i = 1'b1;
    #1;
    nChecks++; if (busA.in_ready_o !== 1'b0) begin nFails++; $display("[TB] FAIL fl_ready: got %b want 0", busA.in_ready_o); end
    tick();
    flushA = 1'b0; busA.in_valid_i = 1'b0;
    #1;
    nChecks++; if (countA !== 2'd0 || emptyA !== 1'b1 || busA.out_valid_o !== 1'b0) begin nFails++; $display("[TB] FAIL fl_post: count %0d empty %b valid %b want 0 1 0", countA, emptyA, busA.out_valid_o); end
    tick();
    nChecks++; if (busA.out_valid_o !== 1'b0) begin nFails++; $display("[TB] FAIL fl_ghost: valid %b data %h want 0", busA.out_valid_o, busA.out_data_o); end
    busA.out_ready_i = 1'b0; busA.in_valid_i = 1'b1; busA.in_data_i = DW'('h11);
    tick();
    busA.in_valid_i = 1'b0;
    nChecks++; if (busA.out_data_o !== DW'('h11) || countA !== 2'd1) begin nFails++; $display("[TB] FAIL fl_refill: data %h count %0d want 11 1", busA.out_data_o, countA); end
    busA.out_ready_i = 1'b1;
    tick();
    busA.out_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    busA.in_valid_i = 1'b1; busA.in_data_i = DW'('h21);
    tick();
    busA.in_data_i = DW'('h22);
    tick();
    busA.in_valid_i = 1'b0;
    nChecks++; if (countA !== 2'd2) begin nFails++; $display("[TB] FAIL rm_pre: count %0d want 2", countA); end
    #2 rstN = 1'b0;
    #1;
    nChecks++; if (busA.out_valid_o !== 1'b0 || countA !== 2'd0 || emptyA !== 1'b1 || busA.out_data_o !== DW'(0)) begin
      nFails++; $display("[TB] FAIL rm_async: valid %b count %0d empty %b data %h want 0 0 1 0", busA.out_valid_o, countA, emptyA, busA.out_data_o);
    end
    #1 rstN = 1'b1;
    tick();
  endtask

  task automatic test_bubble_drop();
    busB.in_valid_i = 1'b1; busB.in_data_i = DW'('h30); busB.out_ready_i = 1'b0;
    #1;
    nChecks++; if (busB.in_ready_o !== 1'b1 || busB.out_valid_o !== 1'b0) begin nFails++; $display("[TB] FAIL bub_hs: ready %b valid %b want 1 0", busB.in_ready_o, busB.out_valid_o); end
    tick();
    busB.out_ready_i = 1'b1;
    #1;
    nChecks++; if (countB !== 3'd0 || emptyB !== 1'b1 || busB.out_valid_o !== 1'b0) begin nFails++; $display("[TB] FAIL bub_count: count %0d empty %b valid %b want 0 1 0", countB, emptyB, busB.out_valid_o); end
    tick();
    busB.in_valid_i = 1'b0; busB.out_ready_i = 1'b0;
  endtask

  task automatic test_bypass();
    busB.in_valid_i = 1'b1; busB.in_data_i = DW'('h41); busB.out_ready_i = 1'b1;
    #1;
    nChecks++; if (busB.out_valid_o !== 1'b1 || busB.out_data_o !== DW'('h41)) begin nFails++; $display("[TB] FAIL byp_same: valid %b data %h want 1 41", busB.out_valid_o, busB.out_data_o); end
    tick();
    nChecks++; if (countB !== 3'd0) begin nFails++; $display("[TB] FAIL byp_count: got %0d want 0", countB); end
    busB.in_data_i = DW'('h43); busB.out_ready_i = 1'b0;
    tick();
    busB.in_data_i = DW'('h45); busB.out_ready_i = 1'b1;
    #1;
    nChecks++; if (countB !== 3'd1 || busB.out_data_o !== DW'('h43)) begin nFails++; $display("[TB] FAIL byp_stored: count %0d data %h want 1 43", countB, busB.out_data_o); end
    tick();
    busB.in_valid_i = 1'b0;
    #1;
    nChecks++; if (countB !== 3'd1 || busB.out_data_o !== DW'('h45)) begin nFails++; $display("[TB] FAIL byp_next: count %0d data %h want 1 45", countB, busB.out_data_o); end
    tick();
    busB.out_ready_i = 1'b0;
  endtask

  task automatic test_wrap();
    logic [DW-1:0] words [10];
    int sent = 0;
    int recv = 0;
    int cycles = 0;
    bit inOk, outOk;
    for (int i = 0; i < 10; i++) words[i] = DW'(32'h101 + 2 * i);
    while (recv < 10 && cycles < 300) begin
      busB.in_valid_i  = (sent < 10);
      busB.in_data_i   = (sent < 10) ? words[sent] : DW'(0);
      busB.out_ready_i = (cycles % 5 == 4) ? 1'b0 : 1'($urandom_range(0, 1));
      #1;
      inOk  = busB.in_valid_i && busB.in_ready_o;
      outOk = busB.out_valid_o && busB.out_ready_i;
      if (outOk) begin
        nChecks++;
        if (busB.out_data_o !== words[recv]) begin nFails++; $display("[TB] FAIL wrap_word%0d: got %h want %h", recv, busB.out_data_o, words[recv]); end
        recv++;
      end
      if (inOk) sent++;
      tick();
      cycles++;
    end
    busB.in_valid_i = 1'b0; busB.out_ready_i = 1'b0;
    nChecks++; if (recv != 10) begin nFails++; $display("[TB] FAIL wrap_timeout: got %0d words want 10", recv); end
    #1;
    nChecks++; if (countB !== 3'd0) begin nFails++; $display("[TB] FAIL wrap_empty: count %0d want 0", countB); end
  endtask

  initial begin
    nChecks = 0; nFails = 0;
    flushA = 1'b0; flushB = 1'b0;
    busA.in_valid_i = 1'b0; busA.in_data_i = '0; busA.out_ready_i = 1'b0;
    busB.in_valid_i = 1'b0; busB.in_data_i = '0; busB.out_ready_i = 1'b0;
    test_reset();
    test_back_to_back();
    test_push_pop();
    test_flush();
    test_reset_mid();
    test_bubble_drop();
    test_bypass();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/pipe_stage_fifo.md
# pipe_stage_fifo

Parametrised elastic pipeline stage between the core's ID, EX, MEM and WB stages. It replaces a plain stage register with a DEPTH-entry in-order queue that uses a valid/ready handshake on both sides. It adds a synchronous flush, optional bubble dropping and an optional same-cycle bypass. The payload is the packed pipeline bus defined in `struct_pckg`, carried as a flat vector.

## Interface
- `XLEN`, 64: datapath width; sets the payload width through the `struct_pckg` constants; legal values 32 or 64.
- `DEPTH`, 2: number of queue entries; power of two, at least 2.
- `DATA_W`, `PIPE_BUS_W(XLEN)`: payload width in bits.
- `BYPASS`, 0: when 1, an empty queue forwards input to output in the same cycle.
- `DROP_BUBBLES`, 0: when 1, input words whose valid bit is 0 are accepted but not stored.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; one clock, reset is asynchronous and active-low.
- `flush_i`  in  1  synchronous flush of all entries.
- `in_valid_i`  in  1  upstream word valid.
- `in_ready_o`  out  1  stage can accept a word.
- `in_data_i`  in  DATA_W  upstream payload.
- `out_valid_o`  out  1  head word valid.
- `out_ready_i`  in  1  downstream accepts the head word.
- `out_data_o`  out  DATA_W  head payload.
- `count_o`  out  $clog2(DEPTH+1)  current occupancy.
- `full_o` / `empty_o`  out  1  `count_o == DEPTH` / `count_o == 0`.

## Operation
- Storage is a circular buffer with `wr_ptr` and `rd_ptr`, each $clog2(DEPTH) bits wide, plus an occupancy counter `count`.
- Both pointers wrap from DEPTH-1 to 0 naturally.
- Push condition: `in_valid_i & in_ready_o`.
- Pop condition: `out_valid_o & out_ready_i`.
- `in_ready_o = !full_o & !flush_i`. There is no combinational path from `out_ready_i` to `in_ready_o`, so a full queue refuses input even if a pop happens in the same cycle.
- Stored push: writes `mem[wr_ptr]`, increments `wr_ptr`, and increments `count` unless a pop occurs in the same cycle.
- Pop: increments `rd_ptr` and decrements `count` unless a stored push occurs in the same cycle.
- Simultaneous stored push and pop: `count` is unchanged and both pointers advance.
- Outputs when BYPASS=0:
  - `out_valid_o = !empty_o`.
  - `out_data_o = mem[rd_ptr]`.
- Outputs when BYPASS=1 and the queue is empty:
  - `out_valid_o = in_valid_i & !flush_i`.
  - `out_data_o = in_data_i`.
  - If `out_ready_i` is also high, the word is consumed directly and not stored.
  - Otherwise the word is stored normally.
- Bubble dropping (`DROP_BUBBLES=1`): an input word with bit `PIPE_VALID_BIT` equal to 0 completes the handshake but is not stored. Pointers and count are unchanged, and the word is never bypassed.
- Flush:
  - Takes priority over push and pop in the same cycle.
  - Next cycle: `count=0`, `wr_ptr=rd_ptr=0`.
  - Any word presented during the flush cycle is discarded.
  - Storage contents are not cleared.
- Reset (asynchronous, any time, including mid-transfer): pointers, count and all storage go to 0.
  - `out_valid_o=0`, `out_data_o=0`, `count_o=0`.
  - `empty_o=1`, `full_o=0`, `in_ready_o=1` (when `flush_i` is low).
  - Any in-flight handshake is lost.

## Timing
- BYPASS=0: a word accepted at edge N is visible on `out_valid_o` after edge N. Minimum latency is 1 cycle.
- Sustained throughput is 1 word per cycle whenever `count < DEPTH` and downstream is ready.
- BYPASS=1 with an empty queue: latency is 0 cycles. The path from `in_valid_i`/`in_data_i` to the outputs is combinational.
- `count_o`, `full_o` and `empty_o` are derived from registers only; they have no combinational dependence on inputs.
- Handshake rule: once `out_valid_o` is asserted, the head data stays stable until popped, except under flush or reset.

## Structure
- Add to `struct_pckg`:
  - the function `PIPE_BUS_W(xlen)`;
  - the constant `PIPE_VALID_BIT` (position of `is_valid` in the flattened bus);
  - an XLEN-parametrised field-width set: `PIPE_RF_ADDR_W`, `PIPE_MEM_BE_W = XLEN/8`.
- One sub-module, `pipe_fifo_mem`: DEPTH×DATA_W storage with a synchronous write port and an asynchronous read port. All pointer and count logic stays in the top module.

## Test plan
- Reset check: assert `rst_n=0` mid-operation with `count=2` → immediately `out_valid_o=0`, `count_o=0`, `empty_o=1`, `out_data_o=0`.
- Back-to-back fill (DEPTH=2, BYPASS=0):
  - Stimulus: push words 0xA then 0xB with `out_ready_i=0`.
  - Response: `count_o=2`, `full_o=1`, `in_ready_o=0`.
  - Then raise `out_ready_i=1`: 0xA pops, then 0xB, in order.
- Simultaneous push and pop at count 1: push 0xC while popping the head → `count_o` stays 1 and the head becomes 0xC.
- Flush priority:
  - Stimulus: with `count=2`, assert `flush_i`, `in_valid_i=1` (data 0xD) and `out_ready_i=1`.
  - Response: next cycle `count_o=0`, `empty_o=1`; 0xD never appears at the output.
- Bubble drop (DROP_BUBBLES=1): push a word with `PIPE_VALID_BIT=0` → handshake completes and `count_o` remains 0.
- Bypass and wrap-around:
  - BYPASS=1 with empty queue and `out_ready_i=1`: `out_data_o` equals `in_data_i` in the same cycle and `count_o` stays 0.
  - DEPTH=4: stream 10 sequential words with random `out_ready_i` → all 10 emerge in order.
